// File: rtl/module_uart_reg_ctrl.sv
// UART register stage: control/data registers and a one-byte TX sequencer.
// Optional overrun flag (ctrl bit 2) is built only when UART_OVERRUN_EN is defined.
module module_uart_reg_ctrl #(
    parameter int unsigned TX_TIMEOUT = 2_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic        slc_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_o,
    output logic [7:0]  data_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_done_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i
);

    localparam int unsigned CW =
        (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] tx_cnt;
    logic          send;
    logic          new_rx;
    logic          ovr;
    logic          tx_err;
    logic [7:0]    data_q;
    logic          ctrl_wr;
    logic          data_wr;
    logic          timeout_hit;
    logic          unused_bits;

    assign ctrl_wr = we_i & ~slc_i;
    assign data_wr = we_i & slc_i & (state == IDLE);

    // Last BUSY cycle before the transfer is forcibly aborted.
    assign timeout_hit = (TX_TIMEOUT != 0) && (state == BUSY)
                       && !tx_done_i && (tx_cnt == TO_LAST);

    assign ctrl_o = {28'b0, tx_err, ovr, new_rx, send};
    assign data_o = data_q;

    assign unused_bits = ^{wdata_i[31:8], wdata_i[2]};

    // Bus-writable flags and data register; HW set/clear beats SW writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            send   <= 1'b0;
            new_rx <= 1'b0;
            tx_err <= 1'b0;
            data_q <= 8'h00;
        end else begin
            if (state == DONE)
                send <= 1'b0;
            else if (ctrl_wr && state == IDLE)
                send <= wdata_i[0];

            if (rx_valid_i)
                new_rx <= 1'b1;
            else if (ctrl_wr && !wdata_i[1])
                new_rx <= 1'b0;

            if (timeout_hit)
                tx_err <= 1'b1;
            else if (ctrl_wr && !wdata_i[3])
                tx_err <= 1'b0;

            if (rx_valid_i)
                data_q <= rx_data_i;
            else if (data_wr)
                data_q <= wdata_i[7:0];
        end
    end

`ifdef UART_OVERRUN_EN
    // Overrun: a new byte arrived before SW consumed the previous one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ovr <= 1'b0;
        else if (rx_valid_i && new_rx)
            ovr <= 1'b1;
        else if (ctrl_wr && !wdata_i[2])
            ovr <= 1'b0;
    end
`else
    assign ovr = 1'b0;
`endif

    // TX sequencer: latch byte and pulse start, then wait for done or timeout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            tx_cnt     <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= 8'h00;
        end else begin
            tx_start_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send)
                        state <= START;
                end
                START: begin
                    tx_data_o  <= data_q;
                    tx_start_o <= 1'b1;
                    tx_cnt     <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    if (tx_done_i || timeout_hit)
                        state <= DONE;
                    else if (tx_cnt != '1)
                        tx_cnt <= tx_cnt + CW'(1);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_uart_reg_ctrl.sv
// Testbench for module_uart_reg_ctrl: directed scenarios plus randomized
// register/RX/TX traffic against a transaction-level model of the registers.
module tb_module_uart_reg_ctrl;

`ifdef UART_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        slc = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] ctrl_o;
    logic [7:0]  data_o;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;

    int n_chk = 0;
    int n_ok = 0;

    // Register model
    logic [7:0] exp_data;
    logic       exp_new, exp_ovr, exp_err, exp_send;

    module_uart_reg_ctrl #(.TX_TIMEOUT(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .we_i       (we),
        .slc_i      (slc),
        .wdata_i    (wdata),
        .ctrl_o     (ctrl_o),
        .data_o     (data_o),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_done_i  (tx_done),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_ctrl();
        return {28'b0, exp_err, exp_ovr & OVR_EN, exp_new, exp_send};
    endfunction

    task automatic m_reset();
        exp_data = 8'h00;
        exp_new = 0; exp_ovr = 0; exp_err = 0; exp_send = 0;
    endtask

    task automatic m_ctrl(input logic [31:0] w, input bit idle);
        exp_new &= w[1];
        exp_ovr &= w[2];
        exp_err &= w[3];
        if (idle) exp_send = w[0];
    endtask

    task automatic m_rx(input logic [7:0] b, input logic prev_new);
        if (OVR_EN && prev_new) exp_ovr = 1'b1;
        exp_new = 1'b1;
        exp_data = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic s, input logic [31:0] d,
                         input logic rv, input logic [7:0] rd);
        we = w; slc = s; wdata = d; rx_valid = rv; rx_data = rd;
        step();
        we = 0; rx_valid = 0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tx_start === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        n_chk++;
        if ({ctrl_o, data_o, tx_start, tx_data} !== 49'h0)
            $display("FAIL reset_async: got %h/%h/%b/%h required 0", ctrl_o, data_o, tx_start, tx_data);
        else n_ok++;
        step(); step();
        @(negedge clk); rst_n = 1;
        step();
        m_reset();
        n_chk++;
        if ({ctrl_o, data_o, tx_start, tx_data} !== 49'h0)
            $display("FAIL reset_state: got %h/%h/%b/%h required 0", ctrl_o, data_o, tx_start, tx_data);
        else n_ok++;
    endtask

    task automatic test_tx();
        int lat;
        drive(1, 1, 32'h5A, 0, 0); exp_data = 8'h5A;
        drive(1, 0, 32'h1, 0, 0); m_ctrl(32'h1, 1);
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL tx_send_set: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
        wait_start(lat);
        n_chk++;
        if (lat !== 2) $display("FAIL tx_latency: got %0d required 2", lat);
        else n_ok++;
        n_chk++;
        if (tx_data !== 8'h5A) $display("FAIL tx_data: got %h required 5a", tx_data);
        else n_ok++;
        step();
        n_chk++;
        if (tx_start !== 1'b0) $display("FAIL tx_pulse_width: got %b required 0", tx_start);
        else n_ok++;
        pulse_done(); step();
        exp_send = 0;
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL tx_send_clr: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
    endtask

    task automatic test_rx();
        logic p;
        p = exp_new; drive(0, 0, 0, 1, 8'hC3); m_rx(8'hC3, p);
        n_chk++;
        if ({ctrl_o, data_o} !== {exp_ctrl(), exp_data})
            $display("FAIL rx_capture: got %h/%h required %h/%h", ctrl_o, data_o, exp_ctrl(), exp_data);
        else n_ok++;
        drive(1, 0, 32'h0, 0, 0); m_ctrl(32'h0, 1);
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL rx_clear: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
    endtask

    task automatic test_collision();
        logic p;
        p = exp_new; drive(1, 1, 32'h22, 1, 8'h11); m_rx(8'h11, p);
        n_chk++;
        if (data_o !== 8'h11) $display("FAIL coll_data: got %h required 11", data_o);
        else n_ok++;
        p = exp_new; drive(1, 0, 32'h0, 1, 8'h33);
        m_ctrl(32'h0, 1); m_rx(8'h33, p);
        n_chk++;
        if ({ctrl_o, data_o} !== {exp_ctrl(), exp_data})
            $display("FAIL coll_set_wins: got %h/%h required %h/%h", ctrl_o, data_o, exp_ctrl(), exp_data);
        else n_ok++;
        drive(1, 0, 32'h0, 0, 0); m_ctrl(32'h0, 1);
    endtask

    task automatic test_busy_ignore();
        int lat;
        drive(1, 1, 32'h3C, 0, 0); exp_data = 8'h3C;
        drive(1, 0, 32'h1, 0, 0); m_ctrl(32'h1, 1);
        wait_start(lat);
        drive(1, 1, 32'h99, 0, 0);
        drive(1, 0, 32'h0, 0, 0); m_ctrl(32'h0, 0);
        n_chk++;
        if ({ctrl_o, data_o} !== {exp_ctrl(), exp_data})
            $display("FAIL busy_ignore: got %h/%h required %h/%h", ctrl_o, data_o, exp_ctrl(), exp_data);
        else n_ok++;
        pulse_done(); step(); exp_send = 0;
        n_chk++;
        if ({ctrl_o, tx_data} !== {exp_ctrl(), 8'h3C})
            $display("FAIL busy_complete: got %h/%h required %h/3c", ctrl_o, tx_data, exp_ctrl());
        else n_ok++;
    endtask

    task automatic test_timeout();
        int lat, n;
        drive(1, 0, 32'h1, 0, 0); m_ctrl(32'h1, 1);
        wait_start(lat);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ctrl_o[3] === 1'b1) begin
                n = i;
                break;
            end
        end
        n_chk++;
        if (n !== 16) $display("FAIL to_cycles: got %0d required 16", n);
        else n_ok++;
        step();
        exp_err = 1; exp_send = 0;
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL to_flags: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
        drive(1, 1, 32'h77, 0, 0); exp_data = 8'h77;
        n_chk++;
        if (data_o !== 8'h77) $display("FAIL to_idle: got %h required 77", data_o);
        else n_ok++;
        drive(1, 0, 32'h0, 0, 0); m_ctrl(32'h0, 1);
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL to_err_clr: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
    endtask

    task automatic test_overrun();
        logic p;
        p = exp_new; drive(0, 0, 0, 1, 8'hA1); m_rx(8'hA1, p);
        p = exp_new; drive(0, 0, 0, 1, 8'hB2); m_rx(8'hB2, p);
        n_chk++;
        if ({ctrl_o, data_o} !== {29'b0, OVR_EN, 2'b10, 8'hB2})
            $display("FAIL ovr_set: got %h/%h required %h/b2", ctrl_o, data_o, {29'b0, OVR_EN, 2'b10});
        else n_ok++;
        drive(1, 0, 32'h6, 0, 0); m_ctrl(32'h6, 1);
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL ovr_keep: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
        drive(1, 0, 32'h0, 0, 0); m_ctrl(32'h0, 1);
        n_chk++;
        if (ctrl_o !== exp_ctrl()) $display("FAIL ovr_clear: got %h required %h", ctrl_o, exp_ctrl());
        else n_ok++;
    endtask

    task automatic test_reset_busy();
        int lat;
        bit seen;
        drive(1, 1, 32'hE5, 0, 0);
        drive(1, 0, 32'h1, 0, 0);
        wait_start(lat);
        step();
        rst_n = 0;
        #2;
        n_chk++;
        if ({ctrl_o, data_o, tx_start, tx_data} !== 49'h0)
            $display("FAIL rst_busy: got %h/%h/%b/%h required 0", ctrl_o, data_o, tx_start, tx_data);
        else n_ok++;
        @(negedge clk); rst_n = 1;
        m_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_start !== 1'b0 || ctrl_o !== 32'h0) seen = 1;
        end
        n_chk++;
        if (seen) $display("FAIL rst_no_resume: got activity required none");
        else n_ok++;
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [7:0]  b;
        logic        p;
        int          op, lat, k;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 5);
            w = $urandom;
            b = 8'($urandom);
            p = exp_new;
            case (op)
                0: begin drive(1, 1, w, 0, 0); exp_data = w[7:0]; end
                1: begin drive(0, 0, 0, 1, b); m_rx(b, p); end
                2: begin w[0] = 0; drive(1, 0, w, 0, 0); m_ctrl(w, 1); end
                3: begin drive(1, 1, w, 1, b); m_rx(b, p); end
                4: begin
                    w[0] = 0;
                    drive(1, 0, w, 1, b);
                    m_ctrl(w, 1); m_rx(b, p);
                end
                default: begin
                    logic [7:0] sent;
                    w[0] = 1;
                    drive(1, 0, w, 0, 0); m_ctrl(w, 1);
                    sent = exp_data;
                    wait_start(lat);
                    n_chk++;
                    if ({lat[7:0], tx_data} !== {8'd2, sent})
                        $display("FAIL rnd_start: got %0d/%h required 2/%h", lat, tx_data, sent);
                    else n_ok++;
                    k = $urandom_range(1, 4);
                    for (int j = 0; j < k; j++) begin
                        b = 8'($urandom);
                        p = exp_new;
                        if ($urandom_range(0, 1) == 1) begin
                            drive(0, 0, 0, 1, b); m_rx(b, p);
                        end else step();
                    end
                    pulse_done(); step(); exp_send = 0;
                    n_chk++;
                    if (tx_data !== sent)
                        $display("FAIL rnd_tx_hold: got %h required %h", tx_data, sent);
                    else n_ok++;
                end
            endcase
            n_chk++;
            if (ctrl_o !== exp_ctrl())
                $display("FAIL rnd_ctrl it=%0d op=%0d: got %h required %h", it, op, ctrl_o, exp_ctrl());
            else n_ok++;
            n_chk++;
            if (data_o !== exp_data)
                $display("FAIL rnd_data it=%0d op=%0d: got %h required %h", it, op, data_o, exp_data);
            else n_ok++;
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_tx();
        test_rx();
        test_collision();
        test_busy_ignore();
        test_timeout();
        test_overrun();
        test_reset_busy();
        test_random();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
